// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic loader/sorter pair: loader FSM states and
// the packed block width helper.
package bitonic_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  function automatic int block_width(input int data_width, input int block_depth);
    return data_width * (2 ** block_depth);
  endfunction

endpackage

// File: rtl/bitonic_loader.sv
// Collects serial elements into a packed block of 2**BLOCK_DEPTH slots, pads
// short blocks, and hands each block to the sorter with a one-cycle start pulse.
module bitonic_loader
  import bitonic_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    BLOCK_DEPTH = 1,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = '1
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [DATA_WIDTH-1:0]                            in_data,
  input  logic                                             in_valid,
  input  logic                                             in_last,
  output logic                                             in_ready,
  output logic [block_width(DATA_WIDTH, BLOCK_DEPTH)-1:0]  blk_data,
  output logic                                             blk_valid,
  input  logic                                             blk_done,
  output logic                                             blk_partial,
  output logic [15:0]                                      blk_count
);

  localparam int N     = 2 ** BLOCK_DEPTH;
  localparam int IDX_W = $clog2(N) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg;
  logic [DATA_WIDTH-1:0]   slot_reg [N];
  logic                    partial_reg;
  logic [15:0]             count_reg;

  logic accept;
  logic last_slot;
  logic block_end;

  assign accept    = in_valid && (state_reg == FILL);
  assign last_slot = (idx_reg == LAST_IDX);
  assign block_end = accept && (last_slot || in_last);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL:    if (block_end) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (blk_done) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  // Index only advances within a block; it is cleared when the sorter releases us.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_reg <= '0;
    end else if (state_reg == WAIT && blk_done) begin
      idx_reg <= '0;
    end else if (accept && !block_end) begin
      idx_reg <= idx_reg + 1'b1;
    end
  end

  // Each slot takes the accepted element at its index, or the pad value when a
  // short block closes below it.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      localparam logic [IDX_W-1:0] SLOT = IDX_W'(gi);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slot_reg[gi] <= '0;
        end else if (accept) begin
          if (idx_reg == SLOT) begin
            slot_reg[gi] <= in_data;
          end else if (block_end && (SLOT > idx_reg)) begin
            slot_reg[gi] <= PAD_VALUE;
          end
        end
      end

      assign blk_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      partial_reg <= 1'b0;
    end else if (block_end) begin
      partial_reg <= in_last && !last_slot;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (state_reg == ISSUE) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign in_ready    = (state_reg == FILL);
  assign blk_valid   = (state_reg == ISSUE);
  assign blk_partial = partial_reg;
  assign blk_count   = count_reg;

endmodule

// File: tb/tb_bitonic_loader.sv
// Directed bench for bitonic_loader: a 2-slot instance for the full-block,
// handshake and reset sequences, and a 4-slot instance for padding and wrap.
module tb_bitonic_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Two-slot instance
  logic        r2 = 1'b0;
  logic [7:0]  d2 = '0;
  logic        v2 = 1'b0;
  logic        l2 = 1'b0;
  logic        rdy2;
  logic [15:0] bd2;
  logic        bv2;
  logic        done2 = 1'b0;
  logic        p2;
  logic [15:0] cnt2;

  // Four-slot instance
  logic        r4 = 1'b0;
  logic [7:0]  d4 = '0;
  logic        v4 = 1'b0;
  logic        l4 = 1'b0;
  logic        rdy4;
  logic [31:0] bd4;
  logic        bv4;
  logic        done4 = 1'b0;
  logic        p4;
  logic [15:0] cnt4;

  bitonic_loader #(.DATA_WIDTH(8), .BLOCK_DEPTH(1)) dut2 (
    .clk(clk), .reset(r2), .in_data(d2), .in_valid(v2), .in_last(l2),
    .in_ready(rdy2), .blk_data(bd2), .blk_valid(bv2), .blk_done(done2),
    .blk_partial(p2), .blk_count(cnt2)
  );

  bitonic_loader #(.DATA_WIDTH(8), .BLOCK_DEPTH(2)) dut4 (
    .clk(clk), .reset(r4), .in_data(d4), .in_valid(v4), .in_last(l4),
    .in_ready(rdy4), .blk_data(bd4), .blk_valid(bv4), .blk_done(done4),
    .blk_partial(p4), .blk_count(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst2_ready",   32'(rdy2), 32'd1);
    check("rst2_data",    32'(bd2),  32'h0);
    check("rst2_valid",   32'(bv2),  32'd0);
    check("rst2_partial", 32'(p2),   32'd0);
    check("rst2_count",   32'(cnt2), 32'd0);
    check("rst4_data",    bd4,       32'h0);
    tick();
    r2 = 1'b1;
    r4 = 1'b1;

    // Full two-element block
    v2 = 1'b1; d2 = 8'h35; tick();
    check("full_ready_mid", 32'(rdy2), 32'd1);
    check("full_valid_mid", 32'(bv2),  32'd0);
    d2 = 8'h12; tick();
    check("full_valid",   32'(bv2),  32'd1);
    check("full_data",    32'(bd2),  32'h1235);
    check("full_partial", 32'(p2),   32'd0);
    check("full_ready",   32'(rdy2), 32'd0);
    check("full_cnt_pre", 32'(cnt2), 32'd0);
    v2 = 1'b0; tick();
    check("full_valid_off", 32'(bv2),  32'd0);
    check("full_count",     32'(cnt2), 32'd1);
    check("full_wait_rdy",  32'(rdy2), 32'd0);
    done2 = 1'b1; tick();
    check("full_back_fill", 32'(rdy2), 32'd1);

    // Spurious blk_done in FILL and ISSUE
    tick();
    check("sp_fill_ready", 32'(rdy2), 32'd1);
    v2 = 1'b1; d2 = 8'hAA; tick();
    d2 = 8'hBB; done2 = 1'b0; tick();
    check("sp_issue_valid", 32'(bv2), 32'd1);
    check("sp_issue_data",  32'(bd2), 32'hBBAA);
    v2 = 1'b0; done2 = 1'b1; tick();
    check("sp_wait_ready", 32'(rdy2), 32'd0);
    check("sp_wait_count", 32'(cnt2), 32'd2);
    done2 = 1'b0; tick();
    check("sp_still_wait", 32'(rdy2), 32'd0);
    done2 = 1'b1; tick();
    check("sp_exit_ready", 32'(rdy2), 32'd1);
    done2 = 1'b0;

    // Backpressure with in_valid held through WAIT
    v2 = 1'b1; d2 = 8'h01; tick();
    d2 = 8'h02; tick();
    check("bp_issue_data", 32'(bd2), 32'h0201);
    d2 = 8'h03; tick();
    check("bp_wait_count", 32'(cnt2), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_ready%0d", i), 32'(rdy2), 32'd0);
      check($sformatf("bp_hold_data%0d", i),  32'(bd2),  32'h0201);
    end
    done2 = 1'b1; tick();
    check("bp_fill_ready", 32'(rdy2), 32'd1);
    check("bp_fill_data",  32'(bd2),  32'h0201);
    done2 = 1'b0; tick();
    check("bp_held_accept", 32'(bd2), 32'h0203);
    d2 = 8'h04; tick();
    check("bp_issue2_valid", 32'(bv2), 32'd1);
    check("bp_issue2_data",  32'(bd2), 32'h0403);
    v2 = 1'b0; tick();
    check("bp_count4", 32'(cnt2), 32'd4);
    done2 = 1'b1; tick();
    done2 = 1'b0;

    // in_last without in_valid does nothing
    l2 = 1'b1; tick(); tick();
    check("lastnv_ready", 32'(rdy2), 32'd1);
    check("lastnv_valid", 32'(bv2),  32'd0);
    check("lastnv_data",  32'(bd2),  32'h0403);
    l2 = 1'b0;

    // Reset mid-block
    v2 = 1'b1; d2 = 8'h55; tick();
    check("mid_slot0", 32'(bd2), 32'h0455);
    v2 = 1'b0;
    #2 r2 = 1'b0;
    #1;
    check("mrst_data",    32'(bd2),  32'h0);
    check("mrst_count",   32'(cnt2), 32'd0);
    check("mrst_valid",   32'(bv2),  32'd0);
    check("mrst_partial", 32'(p2),   32'd0);
    check("mrst_ready",   32'(rdy2), 32'd1);
    tick();
    r2 = 1'b1;
    tick(); tick();
    check("mrst_no_valid", 32'(bv2), 32'd0);
    v2 = 1'b1; d2 = 8'h66; tick();
    check("mrst_no_valid2", 32'(bv2), 32'd0);
    d2 = 8'h77; tick();
    check("mrst_valid_new", 32'(bv2), 32'd1);
    check("mrst_data_new",  32'(bd2), 32'h7766);
    v2 = 1'b0; tick();
    check("mrst_count1", 32'(cnt2), 32'd1);
    done2 = 1'b1; tick();
    done2 = 1'b0;

    // Four-slot partial block, single element
    v4 = 1'b1; d4 = 8'h07; l4 = 1'b1; tick();
    check("p1_valid",   32'(bv4), 32'd1);
    check("p1_data",    bd4,      32'hFFFFFF07);
    check("p1_partial", 32'(p4),  32'd1);
    check("p1_ready",   32'(rdy4), 32'd0);
    v4 = 1'b0; l4 = 1'b0; done4 = 1'b1; tick();
    check("p1_wait", 32'(rdy4), 32'd0);
    tick();
    check("p1_refill", 32'(rdy4), 32'd1);
    done4 = 1'b0;

    // Four-slot partial block closing at slot 2
    v4 = 1'b1; d4 = 8'h01; tick();
    d4 = 8'h02; tick();
    d4 = 8'h03; l4 = 1'b1; tick();
    check("p3_valid",   32'(bv4), 32'd1);
    check("p3_data",    bd4,      32'hFF030201);
    check("p3_partial", 32'(p4),  32'd1);
    v4 = 1'b0; l4 = 1'b0; done4 = 1'b1; tick(); tick();
    done4 = 1'b0;

    // Full four-slot block, in_last on the final slot is ignored
    v4 = 1'b1; d4 = 8'h0A; tick();
    d4 = 8'h0B; tick();
    d4 = 8'h0C; tick();
    d4 = 8'h0D; l4 = 1'b1; tick();
    check("f4_valid",   32'(bv4), 32'd1);
    check("f4_data",    bd4,      32'h0D0C0B0A);
    check("f4_partial", 32'(p4),  32'd0);
    v4 = 1'b0; l4 = 1'b0; done4 = 1'b1; tick(); tick();
    done4 = 1'b0;
    check("f4_count", 32'(cnt4), 32'd3);

    // blk_count wrap over 65537 single-element blocks from reset
    r4 = 1'b0; tick();
    r4 = 1'b1;
    check("wrap_rst_count", 32'(cnt4), 32'd0);
    v4 = 1'b1; l4 = 1'b1; d4 = 8'h5A; done4 = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      tick(); tick(); tick();
    end
    check("wrap_count0", 32'(cnt4), 32'd0);
    check("wrap_ready",  32'(rdy4), 32'd1);
    tick(); tick(); tick();
    check("wrap_count1", 32'(cnt4), 32'd1);
    check("wrap_data",   bd4,       32'hFFFFFF5A);
    v4 = 1'b0; l4 = 1'b0; done4 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitonic_loader.md
BITONIC_LOADER -- requirements
Module: bitonic_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the width of one element in bits.
REQ-002 Parameter BLOCK_DEPTH, default 1, sets the block size: N = 2**BLOCK_DEPTH elements per block.
REQ-003 Parameter PAD_VALUE, default all-ones of DATA_WIDTH, is written into unfilled slots of a partial block.
REQ-004 clk  input  1  the single clock; all flops on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  DATA_WIDTH  serial element from upstream.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_last  input  1  qualifies in_data as the final element of a partial block.
REQ-009 in_ready  output  1  loader accepts an element this cycle.
REQ-010 blk_data  output  N*DATA_WIDTH  packed block to the sorter; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 blk_valid  output  1  one-cycle start pulse to the sorter.
REQ-012 blk_done  input  1  sorter completion pulse.
REQ-013 blk_partial  output  1  the issued block contains at least one PAD_VALUE slot.
REQ-014 blk_count  output  16  number of blocks issued since reset; wraps modulo 2**16.

Function
REQ-015 An element SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016 The FSM SHALL have three states: FILL, ISSUE and WAIT.
REQ-017 In FILL, in_ready SHALL be 1; in ISSUE and WAIT, in_ready SHALL be 0.
REQ-018 The k-th accepted element of a block (k from 0) SHALL be written to slot k; fill index width is clog2(N)+1.
REQ-019 FILL->ISSUE SHALL occur on acceptance of slot N-1, or on acceptance of any element with in_last=1.
REQ-020 On an in_last transition, the same clock edge SHALL write PAD_VALUE into slots k+1..N-1 and set blk_partial=1.
REQ-021 On a full-block transition (slot N-1 accepted), blk_partial SHALL be 0 and in_last SHALL be ignored.
REQ-022 In ISSUE, blk_valid SHALL be 1 for exactly one cycle; the state SHALL then move to WAIT and blk_count SHALL increment.
REQ-023 Latency: last element accepted on the edge ending cycle T -> blk_valid=1 in cycle T+1.
REQ-024 blk_data and blk_partial SHALL remain stable from ISSUE until the return to FILL.
REQ-025 WAIT->FILL SHALL occur on blk_done=1; the fill index SHALL clear and in_ready SHALL be 1 in the next cycle.
REQ-026 blk_done SHALL be ignored in FILL and ISSUE.
REQ-027 in_valid, in_data and in_last SHALL be ignored in ISSUE and WAIT; no element is lost or buffered.
REQ-028 blk_count SHALL wrap from 16'hFFFF to 0 without any other effect.
REQ-029 in_last on a cycle where in_valid=0 SHALL have no effect.

Reset
REQ-030 On reset=0, regardless of clk, the loader SHALL enter FILL with fill index 0.
REQ-031 Reset values SHALL be: in_ready 1 once reset releases, blk_data 0, blk_valid 0, blk_partial 0, blk_count 0.
REQ-032 Reset asserted mid-block or in WAIT SHALL discard the partial block; no blk_valid SHALL follow reset release until a new block completes.

Structure
REQ-033 The state enum (FILL, ISSUE, WAIT) SHALL live in the shared package bitonic_pkg, alongside a block-width function N*DATA_WIDTH used by both loader and sorter.
REQ-034 The loader SHALL be a single module with no sub-modules; blk_data connects directly to the sorter's data_in and blk_valid to its valid.

Verification
REQ-035 Full block, N=2, DATA_WIDTH=8: accept 8'h35 then 8'h12 -> blk_data=16'h1235, blk_partial=0, one-cycle blk_valid the cycle after 8'h12, blk_count=1.
REQ-036 Partial block, N=4: accept 8'h07 with in_last=1 -> blk_data=32'hFFFFFF07, blk_partial=1, blk_valid the next cycle.
REQ-037 Backpressure: in_valid held high through WAIT with blk_done delayed 5 cycles -> in_ready=0 for those cycles, no element accepted; the held element is accepted in the first FILL cycle.
REQ-038 Spurious blk_done pulsed during FILL and ISSUE -> no state change; a WAIT exit occurs only on the later blk_done.
REQ-039 Reset pulsed low after one of two elements, N=2 -> all outputs return to reset values; the next two elements form a clean block with blk_count=1.
REQ-040 Issue 65537 blocks -> blk_count reads 1 after the final block.
